// File: rtl/mux4_arbiter_if.sv
// Request/grant bundle between four requesters, the arbiter and the shared dual 1-of-4 mux.
// Bit i of req/gnt belongs to requester i; sel is the binary index of the granted requester.
interface mux4_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       busy;

    modport master (input req, output gnt, output sel, output en, output busy);
    modport slave  (output req, input gnt, input sel, input en, input busy);
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4-way mux, MAXHOLD-bounded grants, one EN-low turn cycle between owners.
// Grant is valid one edge after REQ is sampled; define MUX4ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 > 3.
module mux4_arbiter #(
    parameter int MAXHOLD = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mux4_arbiter_if.master io_arb
);
    localparam int CW = $clog2(MAXHOLD);
    localparam logic [CW-1:0] HMAX = CW'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_gnt;
    logic [1:0]    r_sel;
    logic          r_en;
    logic          r_busy;
    logic [CW-1:0] r_hcnt;
    logic [1:0]    r_last;

    state_t        w_state_nxt;
    logic [3:0]    w_gnt_nxt;
    logic [1:0]    w_sel_nxt;
    logic          w_en_nxt;
    logic          w_busy_nxt;
    logic [CW-1:0] w_hcnt_nxt;
    logic [1:0]    w_last_nxt;
    logic [1:0]    w_win;
    logic          w_any_req;
    logic          w_own_req;
    logic          w_others;

    assign w_any_req = |io_arb.req;
    // r_gnt is the owner's one-hot mask while in OWN
    assign w_own_req = |(io_arb.req & r_gnt);
    assign w_others  = |(io_arb.req & ~r_gnt);

`ifdef MUX4ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (io_arb.req[i]) w_win = 2'(i);
        end
    end
`else
    // Scan offsets from farthest to nearest so the requester right after r_last wins.
    always_comb begin
        w_win = r_last;
        for (int k = 4; k >= 1; k--) begin
            if (io_arb.req[r_last + 2'(k)]) w_win = r_last + 2'(k);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_en_nxt    = r_en;
        w_hcnt_nxt  = r_hcnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE, ST_TURN: begin
                if (w_any_req) begin
                    w_state_nxt = ST_OWN;
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_sel_nxt   = w_win;
                    w_en_nxt    = 1'b1;
                    w_hcnt_nxt  = '0;
                    w_last_nxt  = w_win;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_en_nxt    = 1'b0;
                end
            end
            ST_OWN: begin
                if (!w_own_req || (r_hcnt == HMAX && w_others)) begin
                    w_state_nxt = ST_TURN;
                    w_gnt_nxt   = 4'b0000;
                    w_en_nxt    = 1'b0;
                end else if (r_hcnt != HMAX) begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_en_nxt    = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'b00;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_hcnt  <= '0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign io_arb.gnt  = r_gnt;
    assign io_arb.sel  = r_sel;
    assign io_arb.en   = r_en;
    assign io_arb.busy = r_busy;
endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed scenarios with literal expectations plus randomized REQ traffic
// checked every cycle against a grant-history model.
module tb_mux4_arbiter;
    localparam int MAXHOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mux4_arbiter_if itf ();

    mux4_arbiter #(.MAXHOLD(MAXHOLD)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_arb (itf.master)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the mux, how many cycles it has held it, and who owned last.
    int m_phase;   // 0 = nobody, 1 = owned, 2 = gap cycle
    int m_owner;
    int m_last;
    int m_held;
    int m_sel;

    function automatic int pick(input logic [3:0] r);
        int w;
        w = -1;
`ifdef MUX4ARB_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) if (r[i]) w = i;
`else
        for (int k = 4; k >= 1; k--) if (r[(m_last + k) % 4]) w = (m_last + k) % 4;
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = 3; m_held = 0; m_sel = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_phase == 1) begin
            if (!r[m_owner]) m_phase = 2;
            else if (m_held >= MAXHOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) m_phase = 2;
            else m_held++;
        end else if (r != 4'b0000) begin
            w = pick(r);
            m_owner = w; m_last = w; m_sel = w; m_held = 1; m_phase = 1;
        end else begin
            m_phase = 0;
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("gnt", int'(itf.gnt), (m_phase == 1) ? (1 << m_owner) : 0);
            chk("sel", int'(itf.sel), m_sel);
            chk("en", int'(itf.en), (m_phase == 1) ? 1 : 0);
            chk("busy", int'(itf.busy), (m_phase != 0) ? 1 : 0);
            chk("gnt_onehot0", int'($countones(itf.gnt) <= 1), 1);
            chk("en_implies_gnt", int'(!itf.en || (itf.gnt != 4'b0000)), 1);
            @(posedge clk);
            if (!rst) model_step(itf.req);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n_en;
        int exp_owner;
        int idx;
        logic [3:0] all_req;

        itf.req = 4'b0000;
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", int'(itf.gnt), 0);
        chk("rst_sel", int'(itf.sel), 0);
        chk("rst_en", int'(itf.en), 0);
        chk("rst_busy", int'(itf.busy), 0);
        tick();
        rst = 1'b0;

        // Single requester 1 for 20 cycles, then release.
        itf.req = 4'b0010;
        n_en = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                chk("s1_gnt", int'(itf.gnt), 2);
                chk("s1_sel", int'(itf.sel), 1);
                chk("s1_en", int'(itf.en), 1);
            end
            if (itf.en && itf.gnt == 4'b0010) n_en++;
        end
        chk("s1_en_cycles", n_en, 20);
        itf.req = 4'b0000;
        tick();
        chk("s1_turn_en", int'(itf.en), 0);
        chk("s1_turn_busy", int'(itf.busy), 1);
        chk("s1_turn_sel", int'(itf.sel), 1);
        tick();
        chk("s1_idle_busy", int'(itf.busy), 0);
        // Sub-cycle glitch between edges must be ignored.
        #2 itf.req = 4'b0100;
        #2 itf.req = 4'b0000;
        tick();
        chk("glitch_busy", int'(itf.busy), 0);

        // Everyone requesting: MAXHOLD grant cycles then one gap per owner.
        do_reset();
`ifdef MUX4ARB_FIXED_PRIO_EN
        all_req = 4'b1001;
`else
        all_req = 4'b1111;
`endif
        itf.req = all_req;
        for (int c = 1; c <= 45; c++) begin
            tick();
            idx = (c - 1) % 9;
`ifdef MUX4ARB_FIXED_PRIO_EN
            exp_owner = 0;
`else
            exp_owner = ((c - 1) / 9) % 4;
`endif
            chk("seq_gnt", int'(itf.gnt), (idx < 8) ? (1 << exp_owner) : 0);
            chk("seq_en", int'(itf.en), (idx < 8) ? 1 : 0);
        end

        // Owner 2 drops on the hold-limit edge while requester 0 waits.
        do_reset();
        itf.req = 4'b0100;
        tick();
        chk("s3_gnt", int'(itf.gnt), 4);
        for (int i = 0; i < 7; i++) tick();
        chk("s3_still", int'(itf.gnt), 4);
        itf.req = 4'b0001;
        tick();
        chk("s3_turn_en", int'(itf.en), 0);
        chk("s3_turn_sel", int'(itf.sel), 2);
        tick();
        chk("s3_new_gnt", int'(itf.gnt), 1);
        chk("s3_new_sel", int'(itf.sel), 0);

        // Asynchronous reset while requester 3 owns the mux.
        do_reset();
        itf.req = 4'b1000;
        tick();
        chk("s4_gnt", int'(itf.gnt), 8);
        chk("s4_sel", int'(itf.sel), 3);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("s4_async_gnt", int'(itf.gnt), 0);
        chk("s4_async_en", int'(itf.en), 0);
        chk("s4_async_sel", int'(itf.sel), 0);
        tick();
        rst = 1'b0;
        itf.req = 4'b1111;
        tick();
        chk("s4_first_gnt", int'(itf.gnt), 1);

        // Random traffic; requests persist a few cycles so hold limits get exercised.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) itf.req = 4'($urandom_range(0, 15));
            if (i == 700) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        itf.req = 4'b0000;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Sequencer and arbiter for a shared dual 1-of-4 mux. Four requesters compete for the mux. The block grants one requester at a time and drives the mux's SEL/EN pair so that the granted requester's bit pair reaches B0/B1. Each grant is bounded by a hold limit. A one-cycle dead turn with EN low separates any two owners, so the mux output never switches sources while enabled.

## Interface
- MAXHOLD, default 8: maximum cycles an owner keeps the mux while another requester waits. Legal range is 2..256. The counter width is $clog2(MAXHOLD).

- CLK  in  1  system clock; all state changes on its rising edge
- RESET  in  1  asynchronous, active-high reset
- REQ  in  [0:3]  request per requester; held high while the requester wants the mux, dropped to release it
- GNT  out  [0:3]  one-hot grant, registered; all zero when no owner
- SEL  out  [0:1]  mux select, registered; the binary index of the current or most recent owner
- EN  out  1  mux enable, registered; high only while an owner holds the grant
- BUSY  out  1  high when the state is not IDLE

## Operation
- States:
  - IDLE: no owner, EN=0.
  - OWN: a single owner, EN=1, GNT=onehot(owner), SEL=owner.
  - TURN: one-cycle gap, EN=0, GNT=0, SEL holds the previous owner.
- Arbitration:
  - Default is round-robin. The search starts at (LAST+1) mod 4, where LAST is the index of the previous owner.
  - LAST updates on every entry to OWN.
- IDLE: if any REQ bit is high, go to OWN with the arbitration winner. Otherwise stay in IDLE.
- OWN:
  - HCNT clears on entry and increments each cycle, saturating at MAXHOLD-1.
  - If the owner's REQ is low, go to TURN.
  - Else if HCNT==MAXHOLD-1 and any other REQ bit is high, go to TURN (preemption).
  - Else stay in OWN. The owner may hold the mux indefinitely while no one else requests.
- TURN: if any REQ bit is high, go to OWN with the arbitration winner. Otherwise go to IDLE.
- Boundary cases:
  - Owner drop and hold-limit reached in the same cycle: go to TURN, same as a plain release.
  - Preempted owner still requesting: it takes part in the arbitration at the end of TURN. Under round-robin it has the lowest priority.
  - REQ pulses shorter than one cycle and not sampled on an edge are ignored.
  - GNT is always one-hot or zero. EN=1 implies GNT!=0.
- Reset: applies immediately, mid-grant included.
  - State=IDLE, GNT=0, SEL=2'b00, EN=0, BUSY=0, HCNT=0, LAST=3, so requester 0 wins first.

## Timing
- All outputs are registered. There is no combinational path from REQ to any output.
- REQ rises in IDLE, sampled at edge N: GNT, EN and SEL are valid after edge N.
- Owner REQ low sampled at edge N: EN=0 and GNT=0 after edge N (TURN). The next owner's GNT/EN is valid after edge N+1.
- Back-to-back owners therefore see exactly one EN-low cycle between grants.
- Preemption: the owner holds exactly MAXHOLD cycles (grant cycles counted while a competitor waits from the first cycle), then TURN.

## Configuration
- MUX4ARB_FIXED_PRIO_EN defined:
  - Arbitration is fixed priority, 0 > 1 > 2 > 3. LAST is ignored for selection.
  - Preemption still forces a TURN, but the highest-priority requester re-wins if it is still requesting.
- Undefined: round-robin, as described above.

## Test plan
- Single requester, MAXHOLD=8, REQ=4'b0010 for 20 cycles then 0:
  - GNT=0010, SEL=01, EN=1 one cycle after REQ rises, held all 20 cycles.
  - Then one TURN cycle, then IDLE with BUSY=0.
- All REQ=4'b1111 from reset, round-robin:
  - Owners are 0,1,2,3,0 in turn, each for 8 EN cycles, with exactly one EN=0 cycle between owners.
  - GNT is never multi-hot.
- Owner 2 drops REQ on the same edge HCNT hits 7 while REQ[0] is high: TURN, then owner 0, then SEL=00.
- RESET pulsed mid-grant while owning index 3: GNT=0, EN=0 and SEL=00 immediately, asynchronously. After release with REQ=1111, requester 0 is granted first.
- MUX4ARB_FIXED_PRIO_EN, REQ=4'b1001 held: owner 0 for 8 cycles, TURN, owner 0 again; requester 3 is never granted.
